// File: rtl/alu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the ALU/regfile datapath.
// Optional macro PERF_CNT_EN adds the retired-instruction counter on instret.
module alu_seq_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic            alu_src_imm,
  output logic            reg_wen,
  output logic            illegal,
  output logic            busy,
  output logic [31:0]     instret
);

  localparam int unsigned ILEN  = 32;
  localparam int unsigned IMM_W = 12;
  localparam int unsigned OP_W  = 4;

  localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] ir_q;
  logic [OP_W-1:0] alu_op_q;
  logic            src_imm_q;
  logic            legal_q;
  logic            reg_wen_q;
  logic            illegal_q;
  logic            req_q;
  logic            busy_q;

  logic [OP_W-1:0] alu_op_d;
  logic            src_imm_d;
  logic            legal_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  // Instruction decode from IR; captured into the _q copies in DECODE only.
  always_comb begin
    alu_op_d  = ALU_ADD;
    src_imm_d = 1'b0;
    legal_d   = 1'b0;
    if (opcode == OPC_R) begin
      case ({funct7, funct3})
        10'b0000000_000: begin alu_op_d = ALU_ADD; legal_d = 1'b1; end
        10'b0100000_000: begin alu_op_d = ALU_SUB; legal_d = 1'b1; end
        10'b0000000_110: begin alu_op_d = ALU_OR;  legal_d = 1'b1; end
        10'b0000000_111: begin alu_op_d = ALU_AND; legal_d = 1'b1; end
        default: ;
      endcase
    end else if (opcode == OPC_I) begin
      case (funct3)
        3'b000: begin alu_op_d = ALU_ADD; src_imm_d = 1'b1; legal_d = 1'b1; end
        3'b110: begin alu_op_d = ALU_OR;  src_imm_d = 1'b1; legal_d = 1'b1; end
        3'b111: begin alu_op_d = ALU_AND; src_imm_d = 1'b1; legal_d = 1'b1; end
        default: ;
      endcase
    end
  end

  // Sequencer FSM; req drops for one cycle after reset, then stays up in FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      alu_op_q  <= ALU_ADD;
      src_imm_q <= 1'b0;
      legal_q   <= 1'b0;
      reg_wen_q <= 1'b0;
      illegal_q <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      reg_wen_q <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          req_q <= 1'b1;
          if (req_q && imem_ready) begin
            ir_q    <= imem_rdata;
            req_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          alu_op_q  <= alu_op_d;
          src_imm_q <= src_imm_d;
          legal_q   <= legal_d;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          reg_wen_q <= legal_q;
          illegal_q <= ~legal_q;
          state_q   <= S_WB;
        end
        S_WB: begin
          pc_q    <= pc_q + XLEN'(4);
          req_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] instret_q;

  // Counts legal retirements; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (state_q == S_WB && legal_q) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign rs1_addr    = ir_q[19:15];
  assign rs2_addr    = ir_q[24:20];
  assign rd_addr     = ir_q[11:7];
  assign imm         = {{(XLEN-IMM_W){ir_q[31]}}, ir_q[31:20]};
  assign alu_op      = alu_op_q;
  assign alu_src_imm = src_imm_q;
  assign reg_wen     = reg_wen_q;
  assign illegal     = illegal_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized self-checking bench for alu_seq_ctrl with a second instance
// reset to 0xFFFFFFFC so the PC wrap is exercised on the same stimulus.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        imem_req, reg_wen, illegal, busy, alu_src_imm;
  logic [31:0] imem_addr, pc, imm, instret;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [3:0]  alu_op;

  logic        w_imem_req, w_reg_wen, w_illegal, w_busy, w_alu_src_imm;
  logic [31:0] w_imem_addr, w_pc, w_imm, w_instret;
  logic [4:0]  w_rs1_addr, w_rs2_addr, w_rd_addr;
  logic [3:0]  w_alu_op;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .imm(imm),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_wen(reg_wen),
    .illegal(illegal), .busy(busy), .instret(instret)
  );

  alu_seq_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(w_pc),
    .rs1_addr(w_rs1_addr), .rs2_addr(w_rs2_addr), .rd_addr(w_rd_addr), .imm(w_imm),
    .alu_op(w_alu_op), .alu_src_imm(w_alu_src_imm), .reg_wen(w_reg_wen),
    .illegal(w_illegal), .busy(w_busy), .instret(w_instret)
  );

  // Reference decode: {legal, src_imm, alu_op} from the mnemonic table.
  function automatic logic [5:0] model(input logic [31:0] ins);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd0) return {1'b1, 1'b0, 4'd2};
    if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) return {1'b1, 1'b0, 4'd6};
    if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd6) return {1'b1, 1'b0, 4'd1};
    if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd7) return {1'b1, 1'b0, 4'd0};
    if (opc == 7'h13 && f3 == 3'd0) return {1'b1, 1'b1, 4'd2};
    if (opc == 7'h13 && f3 == 3'd6) return {1'b1, 1'b1, 4'd1};
    if (opc == 7'h13 && f3 == 3'd7) return {1'b1, 1'b1, 4'd0};
    return {1'b0, 1'b0, 4'd2};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  f3;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: begin
        f3 = 3'd0;
        case ($urandom_range(0, 3))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          2: begin r[31:25] = 7'h00; f3 = 3'd6; end
          default: begin r[31:25] = 7'h00; f3 = 3'd7; end
        endcase
        r[14:12] = f3;
        r[6:0]   = 7'h33;
      end
      1: begin
        case ($urandom_range(0, 2))
          0: r[14:12] = 3'd0;
          1: r[14:12] = 3'd6;
          default: r[14:12] = 3'd7;
        endcase
        r[6:0] = 7'h13;
      end
      2: begin r[6:0] = 7'h33; r[31:25] = 7'h01; end
      3: begin r[6:0] = 7'h13; r[14:12] = 3'd1; end
      default: ;
    endcase
    return r;
  endfunction

  // Runs one instruction through all four states, checking each cycle.
  task automatic run_instr(input logic [31:0] ins, input int waits, input bit noise);
    int          n;
    logic [5:0]  m;
    logic [31:0] eimm;
    m    = model(ins);
    eimm = {{20{ins[31]}}, ins[31:20]};
    n    = 0;
    imem_ready = 1'b0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL req_timeout: imem_req=%b required 1 within 20 cycles", imem_req);
      return;
    end
    n_cmp++;
    if ({imem_addr, pc, w_imem_addr, w_pc, busy} !== {exp_pc, exp_pc, exp_pc - 32'd4, exp_pc - 32'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_addr: addr=%h pc=%h waddr=%h wpc=%h busy=%b required pc=%h wpc=%h busy=0",
               imem_addr, pc, w_imem_addr, w_pc, busy, exp_pc, exp_pc - 32'd4);
    end
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      n_cmp++;
      if ({imem_req, imem_addr, busy} !== {1'b1, exp_pc, 1'b0}) begin
        n_fail++;
        $display("FAIL fetch_wait: req=%b addr=%h busy=%b required req=1 addr=%h busy=0",
                 imem_req, imem_addr, busy, exp_pc);
      end
    end
    imem_ready = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_ready = noise;
    imem_rdata = $urandom;
    n_cmp++;
    if ({busy, imem_req, rs1_addr, rs2_addr, rd_addr, imm, w_busy, w_imem_req, w_rs1_addr, w_rs2_addr, w_rd_addr, w_imm}
        !== {1'b1, 1'b0, ins[19:15], ins[24:20], ins[11:7], eimm, 1'b1, 1'b0, ins[19:15], ins[24:20], ins[11:7], eimm}) begin
      n_fail++;
      $display("FAIL decode_fields: busy=%b req=%b rs1=%0d rs2=%0d rd=%0d imm=%h required busy=1 req=0 rs1=%0d rs2=%0d rd=%0d imm=%h",
               busy, imem_req, rs1_addr, rs2_addr, rd_addr, imm, ins[19:15], ins[24:20], ins[11:7], eimm);
    end
    @(negedge clk);
    n_cmp++;
    if ({alu_op, alu_src_imm, reg_wen, illegal, w_alu_op, w_alu_src_imm} !== {m[3:0], m[4], 1'b0, 1'b0, m[3:0], m[4]}) begin
      n_fail++;
      $display("FAIL exec_ctrl: ins=%h op=%b src=%b wen=%b ill=%b required op=%b src=%b wen=0 ill=0",
               ins, alu_op, alu_src_imm, reg_wen, illegal, m[3:0], m[4]);
    end
    @(negedge clk);
    n_cmp++;
    if ({alu_op, alu_src_imm, reg_wen, illegal, w_reg_wen, w_illegal, busy, rd_addr, imm}
        !== {m[3:0], m[4], m[5], ~m[5], m[5], ~m[5], 1'b1, ins[11:7], eimm}) begin
      n_fail++;
      $display("FAIL wb_strobe: ins=%h op=%b src=%b wen=%b ill=%b rd=%0d required op=%b src=%b wen=%b ill=%b rd=%0d",
               ins, alu_op, alu_src_imm, reg_wen, illegal, rd_addr, m[3:0], m[4], m[5], ~m[5], ins[11:7]);
    end
    imem_ready = 1'b0;
    @(negedge clk);
    exp_pc = exp_pc + 32'd4;
`ifdef PERF_CNT_EN
    if (m[5]) exp_instret = exp_instret + 32'd1;
`endif
    n_cmp++;
    if ({pc, w_pc, w_imem_addr, busy, imem_req, reg_wen, instret, w_instret}
        !== {exp_pc, exp_pc - 32'd4, exp_pc - 32'd4, 1'b0, 1'b1, 1'b0, exp_instret, exp_instret}) begin
      n_fail++;
      $display("FAIL retire: pc=%h wpc=%h busy=%b req=%b wen=%b instret=%0d winstret=%0d required pc=%h wpc=%h instret=%0d",
               pc, w_pc, busy, imem_req, reg_wen, instret, w_instret, exp_pc, exp_pc - 32'd4, exp_instret);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst        = 1'b1;
    imem_ready = 1'b0;
    @(negedge clk);
    exp_pc      = 32'h0;
    exp_instret = 32'h0;
    n_cmp++;
    if ({imem_req, busy, reg_wen, illegal, pc, w_pc, alu_op, alu_src_imm, instret, rs1_addr, rd_addr, imm}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 4'd2, 1'b0, 32'd0, 5'd0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: req=%b busy=%b wen=%b ill=%b pc=%h wpc=%h op=%b src=%b instret=%0d imm=%h",
               imem_req, busy, reg_wen, illegal, pc, w_pc, alu_op, alu_src_imm, instret, imm);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({imem_req, busy, reg_wen, pc} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_resume: req=%b busy=%b wen=%b pc=%h required req=1 busy=0 wen=0 pc=0",
               imem_req, busy, reg_wen, pc);
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_directed();
    run_instr(32'h002081B3, 0, 1'b0);  // add x3,x1,x2
    run_instr(32'h402081B3, 3, 1'b0);  // sub x3,x1,x2
    run_instr(32'hFFF0F293, 1, 1'b1);  // andi x5,x1,-1
    run_instr(32'h00000073, 0, 1'b0);  // ecall
    run_instr(32'h00006033, 2, 1'b1);  // or x0,x0,x0
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst        = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h002081B3;
    @(negedge clk);
    n_cmp++;
    if ({imem_req, busy, reg_wen, pc} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_in_fetch: req=%b busy=%b wen=%b pc=%h required req=0 busy=0 wen=0 pc=0",
               imem_req, busy, reg_wen, pc);
    end
    rst        = 1'b0;
    imem_ready = 1'b0;
    exp_pc      = 32'h0;
    exp_instret = 32'h0;
    @(negedge clk);
    n_cmp++;
    if ({imem_req, busy, instret} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_fetch_resume: req=%b busy=%b instret=%0d required req=1 busy=0 instret=0",
               imem_req, busy, instret);
    end
    run_instr(32'h002081B3, 0, 1'b0);
    imem_ready = 1'b1;
    imem_rdata = 32'h002081B3;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({imem_req, busy, reg_wen, pc, instret} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_in_exec: req=%b busy=%b wen=%b pc=%h instret=%0d required req=0 busy=0 wen=0 pc=0 instret=0",
               imem_req, busy, reg_wen, pc, instret);
    end
    rst         = 1'b0;
    exp_pc      = 32'h0;
    exp_instret = 32'h0;
    @(negedge clk);
    n_cmp++;
    if ({imem_req, busy, reg_wen, pc} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_exec_resume: req=%b busy=%b wen=%b pc=%h required req=1 busy=0 wen=0 pc=0",
               imem_req, busy, reg_wen, pc);
    end
  endtask

  task automatic test_perf_cnt();
    logic [31:0] req_cnt;
    apply_reset();
    run_instr(32'h002081B3, 0, 1'b0);
    run_instr(32'h00000073, 1, 1'b0);
    run_instr(32'h0070E293, 0, 1'b1);
    run_instr(32'h402081B3, 2, 1'b0);
`ifdef PERF_CNT_EN
    req_cnt = 32'd3;
`else
    req_cnt = 32'd0;
`endif
    n_cmp++;
    if (instret !== req_cnt) begin
      n_fail++;
      $display("FAIL perf_count: instret=%0d required %0d", instret, req_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      run_instr(rand_instr(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst         = 1'b1;
    imem_ready  = 1'b0;
    imem_rdata  = 32'h0;
    exp_pc      = 32'h0;
    exp_instret = 32'h0;
    test_reset();
    test_directed();
    test_reset_mid();
    test_perf_cnt();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
